tag_nios_system_mem_copy_master: RTL and testbench

Avalon-MM master engine that copies a block of 32-bit words from one region of on-chip memory to another, one word at a time.
It drives the s2 (second) slave port of the system on-chip RAM so block moves run without the Nios II CPU.
A conduit-side control interface starts the copy and reports busy/done status plus a running 32-bit checksum of the copied data.

---
 rtl/tag_nios_system_mem_copy_master_if.sv | 22 ++
 rtl/tag_nios_system_mem_copy_master.sv | 135 +++++++++++++
 tb/tb_tag_nios_system_mem_copy_master.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/tag_nios_system_mem_copy_master_if.sv
// Avalon-MM bus between the copy engine (master) and the on-chip RAM s2 port (slave).
interface tag_nios_system_mem_copy_master_if #(
    parameter int ADDR_W = 13
);
    logic [ADDR_W-1:0] address;
    logic              read;
    logic              write;
    logic [31:0]       writedata;
    logic [3:0]        byteenable;
    logic              waitrequest;
    logic [31:0]       readdata;

    modport master (
        output address, read, write, writedata, byteenable,
        input  waitrequest, readdata
    );

    modport slave (
        input  address, read, write, writedata, byteenable,
        output waitrequest, readdata
    );
endinterface

// File: rtl/tag_nios_system_mem_copy_master.sv
// Word-at-a-time Avalon-MM block copy engine with busy/done status and a running checksum.
module tag_nios_system_mem_copy_master #(
    parameter int ADDR_W       = 13,
    parameter int LEN_W        = 14,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   src_addr,
    input  logic [ADDR_W-1:0]   dst_addr,
    input  logic [LEN_W-1:0]    length,
    output logic                busy,
    output logic                done,
    output logic [31:0]         checksum,
    tag_nios_system_mem_copy_master_if.master avm
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_READ   = 3'd1;
    localparam logic [2:0] S_RDWAIT = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [LEN_W-1:0]  count_q, count_d;
    logic [2:0]        lat_q, lat_d;
    logic [31:0]       data_q, data_d;
    logic [31:0]       checksum_q, checksum_d;
    logic [ADDR_W-1:0] address_q, address_d;
    logic              read_q, read_d;
    logic              write_q, write_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        dst_d      = dst_q;
        count_d    = count_q;
        lat_d      = lat_q;
        data_d     = data_q;
        checksum_d = checksum_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    src_d      = src_addr;
                    dst_d      = dst_addr;
                    count_d    = length;
                    checksum_d = '0;
                    state_d    = (length == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                if (!avm.waitrequest) begin
                    lat_d   = 3'(READ_LATENCY);
                    state_d = S_RDWAIT;
                end
            end
            S_RDWAIT: begin
                if (lat_q == 3'd1) begin
                    data_d     = avm.readdata;
                    checksum_d = checksum_q + avm.readdata;
                    lat_d      = '0;
                    state_d    = S_WRITE;
                end else begin
                    lat_d = lat_q - 3'd1;
                end
            end
            S_WRITE: begin
                if (!avm.waitrequest) begin
                    src_d   = src_q + ADDR_W'(1);
                    dst_d   = dst_q + ADDR_W'(1);
                    count_d = count_q - LEN_W'(1);
                    state_d = (count_q == LEN_W'(1)) ? S_DONE : S_READ;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus strobes are registered from the next state so they line up with the state itself.
    always_comb begin
        read_d    = (state_d == S_READ);
        write_d   = (state_d == S_WRITE);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_DONE);
        address_d = address_q;
        if (state_d == S_READ)
            address_d = src_d;
        else if (state_d == S_WRITE)
            address_d = dst_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            count_q    <= '0;
            lat_q      <= '0;
            data_q     <= '0;
            checksum_q <= '0;
            address_q  <= '0;
            read_q     <= 1'b0;
            write_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            dst_q      <= dst_d;
            count_q    <= count_d;
            lat_q      <= lat_d;
            data_q     <= data_d;
            checksum_q <= checksum_d;
            address_q  <= address_d;
            read_q     <= read_d;
            write_q    <= write_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign avm.address    = address_q;
    assign avm.read       = read_q;
    assign avm.write      = write_q;
    assign avm.writedata  = data_q;
    assign avm.byteenable = 4'hF;
    assign busy           = busy_q;
    assign done           = done_q;
    assign checksum       = checksum_q;
endmodule

// File: tb/tb_tag_nios_system_mem_copy_master.sv
// Randomized scoreboard bench for the memory copy engine against a word-array copy model.
module tb_tag_nios_system_mem_copy_master;
    localparam int AW = 13;
    localparam int LW = 14;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] src_addr, dst_addr;
    logic [LW-1:0] length;
    logic          busy, done;
    logic [31:0]   checksum;

    int n_pass  = 0;
    int n_total = 0;

    tag_nios_system_mem_copy_master_if #(.ADDR_W(AW)) bus ();

    tag_nios_system_mem_copy_master #(
        .ADDR_W(AW), .LEN_W(LW), .READ_LATENCY(1)
    ) dut (
        .clk(clk), .reset(reset), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .length(length),
        .busy(busy), .done(done), .checksum(checksum),
        .avm(bus)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [0:8191];

    typedef struct packed {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;
    wr_t           exp_wr_q[$];
    logic [AW-1:0] exp_rd_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Slave RAM with one-cycle read latency; contents are (re)seeded while reset is high.
    initial begin
        bus.readdata <= '0;
        forever begin
            @(posedge clk);
            if (reset) begin
                for (int i = 0; i < 8192; i++)
                    mem[i] <= (i < 4) ? 32'(i + 1) * 32'h11111111 : $urandom;
            end else begin
                if (bus.read && !bus.waitrequest) bus.readdata <= mem[bus.address];
                if (bus.write && !bus.waitrequest) mem[bus.address] <= bus.writedata;
            end
        end
    end

    // Monitor: every accepted transfer pops the next expected read or write.
    initial begin
        forever begin
            @(posedge clk);
            if (!reset && (bus.read || bus.write) && !bus.waitrequest) begin
                check("rd_wr_exclusive", 64'(bus.read & bus.write), 0);
                check("byteenable", 64'(bus.byteenable), 64'h F);
                if (bus.read) begin
                    check("rd_expected", 64'(exp_rd_q.size() != 0), 1);
                    if (exp_rd_q.size() != 0) check("rd_addr", 64'(bus.address), 64'(exp_rd_q.pop_front()));
                end
                if (bus.write) begin
                    check("wr_expected", 64'(exp_wr_q.size() != 0), 1);
                    if (exp_wr_q.size() != 0) begin
                        wr_t e;
                        e = exp_wr_q.pop_front();
                        check("wr_addr", 64'(bus.address), 64'(e.a));
                        check("wr_data", 64'(bus.writedata), 64'(e.d));
                    end
                end
            end
        end
    end

    // Reference: sequential word copy over a snapshot of the RAM, wrapping addresses.
    task automatic build_exp(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n,
                             output logic [31:0] ck);
        logic [31:0] ref_mem [0:8191];
        logic [AW-1:0] sa, da;
        for (int i = 0; i < 8192; i++) ref_mem[i] = mem[i];
        ck = 0;
        for (int i = 0; i < n; i++) begin
            sa = s + AW'(i);
            da = d + AW'(i);
            exp_rd_q.push_back(sa);
            exp_wr_q.push_back('{a: da, d: ref_mem[sa]});
            ck += ref_mem[sa];
            ref_mem[da] = ref_mem[sa];
        end
    endtask

    task automatic run_copy(input logic [AW-1:0] s, input logic [AW-1:0] d, input int n,
                            input int stall_pct, input bit mid_start);
        logic [31:0]   ck;
        int            cycles, stalls;
        bit            prev_stall, timed_out;
        logic [AW-1:0] p_addr;
        logic          p_rd, p_wr;
        logic [31:0]   p_wd;
        build_exp(s, d, n, ck);
        @(negedge clk);
        bus.waitrequest = 1'b0;
        start = 1'b1; src_addr = s; dst_addr = d; length = LW'(n);
        @(posedge clk);
        cycles = 0; stalls = 0; prev_stall = 0; timed_out = 0;
        forever begin
            @(negedge clk);
            cycles++;
            start = mid_start && (cycles == 5);
            if (start) begin
                src_addr = AW'($urandom); dst_addr = AW'($urandom); length = LW'($urandom_range(1, 9));
            end
            if (cycles == 1) check("busy_rise", 64'(busy), 1);
            if (prev_stall)
                check("stall_hold", 64'({bus.address, bus.read, bus.write, bus.writedata}),
                      64'({p_addr, p_rd, p_wr, p_wd}));
            if (done) break;
            if (cycles > 3 * n + 1 + 4000) begin
                check("done_within_budget", 64'(done), 1);
                timed_out = 1;
                break;
            end
            bus.waitrequest = ($urandom_range(99) < stall_pct);
            p_addr = bus.address; p_rd = bus.read; p_wr = bus.write; p_wd = bus.writedata;
            prev_stall = (bus.read || bus.write) && bus.waitrequest;
            if (prev_stall) stalls++;
        end
        bus.waitrequest = 1'b0;
        start = 1'b0;
        if (!timed_out) begin
            check("done_cycles", 64'(cycles), 64'(3 * n + 1 + stalls));
            check("busy_at_done", 64'(busy), 1);
            check("checksum", 64'(checksum), 64'(ck));
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("done_single_pulse", 64'(done), 0);
            check("busy_idle", 64'(busy), 0);
        end
        check("checksum_hold", 64'(checksum), 64'(ck));
        check("rd_q_drained", 64'(exp_rd_q.size()), 0);
        check("wr_q_drained", 64'(exp_wr_q.size()), 0);
        exp_rd_q.delete();
        exp_wr_q.delete();
    endtask

    task automatic reset_mid_write();
        logic [31:0] ck;
        int          n;
        build_exp(13'd500, 13'd600, 8, ck);
        @(negedge clk);
        start = 1'b1; src_addr = 13'd500; dst_addr = 13'd600; length = LW'(8);
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (!bus.write && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reached_write", 64'(bus.write), 1);
        #2 reset = 1'b1;
        #1;
        check("rst_read", 64'(bus.read), 0);
        check("rst_write", 64'(bus.write), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_done", 64'(done), 0);
        @(posedge clk);
        @(negedge clk);
        check("rst_no_done", 64'(done), 0);
        reset = 1'b0;
        exp_rd_q.delete();
        exp_wr_q.delete();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        src_addr = '0; dst_addr = '0; length = '0;
        bus.waitrequest = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 0);
        check("reset_done", 64'(done), 0);
        check("reset_read", 64'(bus.read), 0);
        check("reset_write", 64'(bus.write), 0);
        check("reset_addr", 64'(bus.address), 0);
        check("reset_checksum", 64'(checksum), 0);
        check("reset_byteenable", 64'(bus.byteenable), 64'hF);
        reset = 1'b0;
        @(negedge clk);

        run_copy(13'd0, 13'd100, 4, 0, 0);
        check("t1_checksum_const", 64'(checksum), 64'hAAAAAAAA);
        for (int i = 0; i < 4; i++)
            check("t1_mem", 64'(mem[100 + i]), 64'(32'(i + 1) * 32'h11111111));

        run_copy(13'd5, 13'd200, 0, 0, 0);
        check("t2_checksum_zero", 64'(checksum), 0);

        run_copy(13'd300, 13'd1000, 16, 50, 0);
        run_copy(13'd8190, 13'd10, 4, 0, 0);
        run_copy(13'd2000, 13'd3000, 10, 0, 1);

        reset_mid_write();
        run_copy(13'd40, 13'd4000, 6, 25, 0);

        for (int t = 0; t < 5; t++)
            run_copy(AW'($urandom), AW'($urandom), $urandom_range(1, 20), $urandom_range(0, 60), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
